alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datapath width of the accumulator, operand and ALU ports.
REQ-002 The block SHALL have parameter SETTLE, default 1, legal range 1..15, giving the number of cycles an operation is held on the ALU before its result is captured.

Interface
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmdValid  input  1  a command is presented.
REQ-006 cmdReady  output  1  the sequencer accepts a command this cycle.
REQ-007 cmdOp  input  4  command opcode, using the ALU opcode map: AND 0000, OR 0001, NOT 0010, XOR 0011, NAND 0100, NOR 0101, XNOR 0110, ADD 1000, SUB 1001, SHRIGHT 1010, SHLEFT 1011, CLEAR 1111.
REQ-008 cmdData  input  WIDTH  command operand (B operand).
REQ-009 aluOp  output  4  opcode driven to the ALU control logic.
REQ-010 aluA  output  WIDTH  ALU A operand (the accumulator).
REQ-011 aluB  output  WIDTH  ALU B operand.
REQ-012 aluResult  input  WIDTH  combinational ALU result.
REQ-013 aluCarry  input  1  ALU carry/borrow out.
REQ-014 accOut  output  WIDTH  accumulator value.
REQ-015 carryFlag  output  1  carry from the last ADD/SUB.
REQ-016 errFlag  output  1  sticky illegal-opcode flag.
REQ-017 doneValid  output  1  one-cycle pulse when a command completes.
REQ-018 busy  output  1  high when the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states, IDLE, EXEC and DONE, and SHALL be encoded in registers only.
REQ-020 In IDLE: cmdReady=1; on cmdValid=1 the block SHALL latch cmdOp/cmdData into opReg/dataReg and go to EXEC with cnt=SETTLE.
REQ-021 In EXEC and DONE: cmdReady=0; cmdValid is ignored and no command is lost, since the requester holds it until cmdReady=1.
REQ-022 In EXEC: aluOp=opReg, aluA=accOut, aluB=dataReg; cnt decrements each cycle.
REQ-023 The edge at which cnt=1 in EXEC SHALL write aluResult into the accumulator and go to DONE.
REQ-024 Latency: a command accepted at edge N SHALL update accOut at edge N+SETTLE, and doneValid SHALL be high for the cycle after edge N+SETTLE.
REQ-025 In DONE: doneValid=1 for exactly one cycle, then IDLE; the earliest next accept is one cycle later, so back-to-back throughput is one command per SETTLE+2 cycles.
REQ-026 In IDLE and DONE: aluOp=1111, aluA=accOut, aluB=0.
REQ-027 ADD/SUB SHALL also write carryFlag<=aluCarry at the capture edge; all other opcodes leave carryFlag unchanged.
REQ-028 CLEAR SHALL set the accumulator to 0 and clear carryFlag and errFlag at the capture edge, independent of aluResult.
REQ-029 Illegal opcodes (0111, 1100, 1101, 1110) SHALL NOT be driven to the ALU; aluOp=1111 in EXEC for these.
REQ-030 An illegal opcode SHALL leave accOut and carryFlag unchanged, SHALL set errFlag=1 at the capture edge, and SHALL still complete with a doneValid pulse.
REQ-031 errFlag SHALL clear only on reset or on completion of a CLEAR command.
REQ-032 busy SHALL be 1 in EXEC and DONE and 0 in IDLE.
REQ-033 Arithmetic is performed by the ALU; the sequencer SHALL capture aluResult unmodified (WIDTH bits, no extension).

Reset
REQ-034 With rst=1 at a rising edge, the block SHALL go to IDLE and set accumulator=0, carryFlag=0, errFlag=0, doneValid=0, busy=0, cnt=0, opReg=1111 and dataReg=0.
REQ-035 During and after reset: cmdReady=1, aluOp=1111, aluB=0.
REQ-036 Reset SHALL take priority over every other event, including a command being accepted or a capture edge in the same cycle.
REQ-037 A reset during EXEC or DONE SHALL abort the command without writing the accumulator or pulsing doneValid.

Verification
REQ-038 Reset: hold rst=1 for 2 cycles with cmdValid=1 -> accOut=0, flags=0, cmdReady=1, aluOp=1111, no doneValid.
REQ-039 ADD, SETTLE=1: accumulator=0, ADD data=0x0005 with model ALU -> accOut=0x0005 one edge after accept; doneValid high the next cycle; carryFlag=0; cmdReady=0 for 2 cycles.
REQ-040 SUB borrow: accumulator=0x0003, SUB data=0x0005 -> accOut=0xFFFE and carryFlag=aluCarry as driven by the model; a following AND data=0xFFFF leaves carryFlag unchanged.
REQ-041 Illegal then CLEAR: accumulator=0x1234, cmdOp=1101 -> aluOp=1111 in EXEC, accOut stays 0x1234, errFlag=1, doneValid pulses; then CLEAR -> accOut=0, errFlag=0, carryFlag=0.
REQ-042 Back-to-back, SETTLE=3: cmdValid held high with 3 queued commands -> accepts spaced exactly 5 cycles apart, one doneValid pulse per command, and aluOp stable for 3 EXEC cycles each.
REQ-043 Reset mid-operation: assert rst in the second EXEC cycle of an ADD with SETTLE=3 -> accOut=0, no doneValid, IDLE next cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command sequencer in front of a combinational ALU: accepts one command, holds it
// on the ALU for SETTLE cycles, captures the result into the accumulator, then pulses done.
module alu_sequencer #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [3:0]       cmdOp,
    input  logic [WIDTH-1:0] cmdData,
    output logic [3:0]       aluOp,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    input  logic [WIDTH-1:0] aluResult,
    input  logic             aluCarry,
    output logic [WIDTH-1:0] accOut,
    output logic             carryFlag,
    output logic             errFlag,
    output logic             doneValid,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CLEAR = 4'b1111;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0]       state_reg;
    logic [3:0]       cnt_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic             err_reg;

    // Opcode legality table: 0111 and 1100..1110 are holes in the ALU opcode map.
    logic [15:0] legal_map;
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_legal
            localparam bit ILLEGAL = (gi == 7) || ((gi >= 12) && (gi <= 14));
            assign legal_map[gi] = !ILLEGAL;
        end
    endgenerate

    logic op_legal;
    assign op_legal = legal_map[op_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= OP_CLEAR;
            data_reg  <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmdValid) begin
                        op_reg    <= cmdOp;
                        data_reg  <= cmdData;
                        cnt_reg   <= SETTLE_CNT;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg == 4'd1) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= DONE;
                        if (op_reg == OP_CLEAR) begin
                            acc_reg   <= '0;
                            carry_reg <= 1'b0;
                            err_reg   <= 1'b0;
                        end else if (!op_legal) begin
                            err_reg <= 1'b1;
                        end else begin
                            acc_reg <= aluResult;
                            if ((op_reg == OP_ADD) || (op_reg == OP_SUB)) begin
                                carry_reg <= aluCarry;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state only, so doneValid/busy are glitch-free.
    always_comb begin
        cmdReady  = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        doneValid = (state_reg == DONE);
        aluOp     = OP_CLEAR;
        aluA      = acc_reg;
        aluB      = '0;
        if (state_reg == EXEC) begin
            aluOp = op_legal ? op_reg : OP_CLEAR;
            aluB  = data_reg;
        end
    end

    assign accOut    = acc_reg;
    assign carryFlag = carry_reg;
    assign errFlag   = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with SETTLE=1, one with SETTLE=3,
// each driven by a small behavioural ALU.
module tb_alu_sequencer;

    logic clk;

    logic        rst1, v1, rdy1, acar1, cf1, ef1, dv1, bz1;
    logic [3:0]  op1, aop1;
    logic [15:0] d1, aa1, ab1, ares1, acc1;

    logic        rst3, v3, rdy3, acar3, cf3, ef3, dv3, bz3;
    logic [3:0]  op3, aop3;
    logic [15:0] d3, aa3, ab3, ares3, acc3;

    int n_vec  = 0;
    int n_miss = 0;
    int dc1    = 0;
    int dc3    = 0;

    logic [3:0]  q_op  [0:2];
    logic [15:0] q_dat [0:2];
    int          acc_cyc  [0:2];
    int          exec_cnt [0:2];

    alu_sequencer #(.WIDTH(16), .SETTLE(1)) u_seq1 (
        .clk(clk), .rst(rst1), .cmdValid(v1), .cmdReady(rdy1), .cmdOp(op1), .cmdData(d1),
        .aluOp(aop1), .aluA(aa1), .aluB(ab1), .aluResult(ares1), .aluCarry(acar1),
        .accOut(acc1), .carryFlag(cf1), .errFlag(ef1), .doneValid(dv1), .busy(bz1)
    );

    alu_sequencer #(.WIDTH(16), .SETTLE(3)) u_seq3 (
        .clk(clk), .rst(rst3), .cmdValid(v3), .cmdReady(rdy3), .cmdOp(op3), .cmdData(d3),
        .aluOp(aop3), .aluA(aa3), .aluB(ab3), .aluResult(ares3), .aluCarry(acar3),
        .accOut(acc3), .carryFlag(cf3), .errFlag(ef3), .doneValid(dv3), .busy(bz3)
    );

    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            4'h0:    alu_model = {1'b0, a & b};
            4'h1:    alu_model = {1'b0, a | b};
            4'h2:    alu_model = {1'b0, ~a};
            4'h3:    alu_model = {1'b0, a ^ b};
            4'h4:    alu_model = {1'b0, ~(a & b)};
            4'h5:    alu_model = {1'b0, ~(a | b)};
            4'h6:    alu_model = {1'b0, ~(a ^ b)};
            4'h8:    alu_model = 17'(a) + 17'(b);
            4'h9:    alu_model = {(a < b), 16'(a - b)};
            4'hA:    alu_model = {1'b0, a >> 1};
            4'hB:    alu_model = {1'b0, a << 1};
            default: alu_model = 17'd0;
        endcase
    endfunction

    always_comb {acar1, ares1} = alu_model(aop1, aa1, ab1);
    always_comb {acar3, ares3} = alu_model(aop3, aa3, ab3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dv1 === 1'b1) dc1++;
        if (dv3 === 1'b1) dc3++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Full command on the SETTLE=1 instance, starting and ending in IDLE.
    task automatic cmd1(input logic [3:0] op, input logic [15:0] data);
        v1  = 1'b1;
        op1 = op;
        d1  = data;
        @(posedge clk); #1;
        v1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("cmd1 op=%h data=%h -> acc=%h carry=%b err=%b", op, data, acc1, cf1, ef1);
    endtask

    initial begin
        int idx;
        int cyc;
        int op_bad;
        int base;
        logic take;

        rst1 = 1'b1; v1 = 1'b1; op1 = 4'h8; d1 = 16'h0005;
        rst3 = 1'b1; v3 = 1'b0; op3 = 4'h0; d3 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc",   acc1, 16'h0000);
        check("rst_carry", 16'(cf1), 16'h0);
        check("rst_err",   16'(ef1), 16'h0);
        check("rst_ready", 16'(rdy1), 16'h1);
        check("rst_aluop", 16'(aop1), 16'h000F);
        check("rst_alub",  ab1, 16'h0000);
        check("rst_done",  16'(dv1), 16'h0);
        check("rst_busy",  16'(bz1), 16'h0);
        check("rst_dcnt",  16'(dc1), 16'h0);
        check("rst3_acc",  acc3, 16'h0000);

        // ADD 5 with SETTLE=1: request already held, accepted on first edge after reset
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;
        check("add_ready_lo", 16'(rdy1), 16'h0);
        check("add_busy",     16'(bz1), 16'h1);
        check("add_aluop",    16'(aop1), 16'h0008);
        check("add_alua",     aa1, 16'h0000);
        check("add_alub",     ab1, 16'h0005);
        v1 = 1'b0;
        @(posedge clk); #1;
        check("add_acc",      acc1, 16'h0005);
        check("add_done",     16'(dv1), 16'h1);
        check("add_carry",    16'(cf1), 16'h0);
        check("add_ready_lo2", 16'(rdy1), 16'h0);
        check("add_aluop_done", 16'(aop1), 16'h000F);
        @(posedge clk); #1;
        check("add_done_off", 16'(dv1), 16'h0);
        check("add_ready_hi", 16'(rdy1), 16'h1);
        check("add_dcnt",     16'(dc1), 16'h1);

        // SUB with borrow, AND keeps carry, ADD overflow and no-carry
        cmd1(4'hF, 16'h0000);
        cmd1(4'h8, 16'h0003);
        check("pre_sub_acc", acc1, 16'h0003);
        cmd1(4'h9, 16'h0005);
        check("sub_acc",   acc1, 16'hFFFE);
        check("sub_carry", 16'(cf1), 16'h1);
        cmd1(4'h0, 16'hFFFF);
        check("and_acc",   acc1, 16'hFFFE);
        check("and_carry", 16'(cf1), 16'h1);
        cmd1(4'h8, 16'h0003);
        check("addov_acc",   acc1, 16'h0001);
        check("addov_carry", 16'(cf1), 16'h1);
        cmd1(4'h8, 16'h0001);
        check("add2_acc",   acc1, 16'h0002);
        check("add2_carry", 16'(cf1), 16'h0);

        // Illegal opcode, sticky error, then CLEAR
        cmd1(4'hF, 16'h0000);
        cmd1(4'h8, 16'hFFFF);
        cmd1(4'h8, 16'h1235);
        check("pre_ill_acc",   acc1, 16'h1234);
        check("pre_ill_carry", 16'(cf1), 16'h1);
        v1 = 1'b1; op1 = 4'hD; d1 = 16'h5555;
        @(posedge clk); #1;
        check("ill_aluop", 16'(aop1), 16'h000F);
        v1 = 1'b0;
        @(posedge clk); #1;
        check("ill_acc",   acc1, 16'h1234);
        check("ill_err",   16'(ef1), 16'h1);
        check("ill_carry", 16'(cf1), 16'h1);
        check("ill_done",  16'(dv1), 16'h1);
        @(posedge clk); #1;
        cmd1(4'h1, 16'h0000);
        check("or_acc",     acc1, 16'h1234);
        check("err_sticky", 16'(ef1), 16'h1);
        cmd1(4'hF, 16'h0000);
        check("clr_acc",   acc1, 16'h0000);
        check("clr_err",   16'(ef1), 16'h0);
        check("clr_carry", 16'(cf1), 16'h0);

        // Reset on the capture edge wins over the capture
        cmd1(4'h8, 16'h0007);
        check("pre_rp_acc", acc1, 16'h0007);
        base = dc1;
        v1 = 1'b1; op1 = 4'h8; d1 = 16'h0001;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        check("rp_acc",   acc1, 16'h0000);
        check("rp_done",  16'(dv1), 16'h0);
        check("rp_ready", 16'(rdy1), 16'h1);
        rst1 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rp_nodone", 16'(dc1 - base), 16'h0);

        // Back-to-back with SETTLE=3 and the request held high
        q_op[0] = 4'h8; q_dat[0] = 16'h0001;
        q_op[1] = 4'h8; q_dat[1] = 16'h0002;
        q_op[2] = 4'h3; q_dat[2] = 16'h00F0;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i]  = 0;
            exec_cnt[i] = 0;
        end
        idx = 0; cyc = 0; op_bad = 0; base = dc3;
        v3 = 1'b1; op3 = q_op[0]; d3 = q_dat[0];
        for (int c = 0; c < 40 && (dc3 - base) < 3; c++) begin
            @(negedge clk);
            if (bz3 && !dv3 && idx > 0) begin
                exec_cnt[idx-1]++;
                if (aop3 !== q_op[idx-1]) op_bad++;
            end
            take = v3 && rdy3;
            @(posedge clk); #1;
            cyc++;
            if (take) begin
                acc_cyc[idx] = cyc;
                $display("b2b accept cmd %0d op=%h at cycle %0d", idx, q_op[idx], cyc);
                idx++;
                if (idx < 3) begin
                    op3 = q_op[idx];
                    d3  = q_dat[idx];
                end else begin
                    v3 = 1'b0;
                end
            end
        end
        check("b2b_accepts", 16'(idx), 16'd3);
        check("b2b_dones",   16'(dc3 - base), 16'd3);
        check("b2b_gap01",   16'(acc_cyc[1] - acc_cyc[0]), 16'd5);
        check("b2b_gap12",   16'(acc_cyc[2] - acc_cyc[1]), 16'd5);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_exec%0d", i), 16'(exec_cnt[i]), 16'd3);
        end
        check("b2b_op_bad", 16'(op_bad), 16'd0);
        check("b2b_acc",    acc3, 16'h00F3);

        // Reset in the second EXEC cycle of an ADD, SETTLE=3
        v3 = 1'b1; op3 = 4'h8; d3 = 16'h0001;
        @(posedge clk); #1;
        v3 = 1'b0;
        @(posedge clk); #1;
        check("mr_busy", 16'(bz3), 16'h1);
        base = dc3;
        rst3 = 1'b1;
        @(posedge clk); #1;
        check("mr_acc",   acc3, 16'h0000);
        check("mr_busy0", 16'(bz3), 16'h0);
        check("mr_ready", 16'(rdy3), 16'h1);
        check("mr_aluop", 16'(aop3), 16'h000F);
        rst3 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mr_nodone", 16'(dc3 - base), 16'h0);
        check("mr_acc2",   acc3, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
